// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: control-word bit map,
// opcodes, T-state encodings and the per-opcode last-step lookup.
package cpu_ctrl_pkg;

    localparam int HLT = 15;
    localparam int MI  = 14;
    localparam int RI  = 13;
    localparam int RO  = 12;
    localparam int IO  = 11;
    localparam int II  = 10;
    localparam int AI  = 9;
    localparam int AO  = 8;
    localparam int EO  = 7;
    localparam int SU  = 6;
    localparam int BI  = 5;
    localparam int OI  = 4;
    localparam int CE  = 3;
    localparam int CO  = 2;
    localparam int J   = 1;
    localparam int FI  = 0;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] STEP_T0 = 3'd0;
    localparam logic [2:0] STEP_T1 = 3'd1;
    localparam logic [2:0] STEP_T2 = 3'd2;
    localparam logic [2:0] STEP_T3 = 3'd3;
    localparam logic [2:0] STEP_T4 = 3'd4;

    typedef logic [15:0] ctrl_word_t;

    typedef struct packed {
        ctrl_word_t ctrl;
        logic       last;
    } uop_t;

    function automatic ctrl_word_t ctrl_bit(input int idx);
        return 16'h0001 << idx;
    endfunction

    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: last_step = STEP_T3;
            OP_ADD, OP_SUB: last_step = STEP_T4;
            default:        last_step = STEP_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the instruction register / flags and the sequencer outputs.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [3:0] opcode;
    logic       cf;
    logic       zf;
    ctrl_word_t ctrl;
    logic [2:0] step;
    logic       halted;

    modport master (output opcode, cf, zf, input ctrl, step, halted);
    modport slave  (input opcode, cf, zf, output ctrl, step, halted);
endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and last-step marker.
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_step,
    input  logic       i_cf,
    input  logic       i_zf,
    output uop_t       o_uop
);

    ctrl_word_t w_ctrl;

    // Control word decode; every unlisted step/opcode pair issues nothing
    always_comb begin
        w_ctrl = 16'h0000;
        case (i_step)
            STEP_T0: w_ctrl = ctrl_bit(CO) | ctrl_bit(MI);
            STEP_T1: w_ctrl = ctrl_bit(RO) | ctrl_bit(II) | ctrl_bit(CE);
            STEP_T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w_ctrl = ctrl_bit(IO) | ctrl_bit(MI);
                    OP_LDI: w_ctrl = ctrl_bit(IO) | ctrl_bit(AI);
                    OP_JMP: w_ctrl = ctrl_bit(IO) | ctrl_bit(J);
                    OP_JC: begin
                        if (i_cf) w_ctrl = ctrl_bit(IO) | ctrl_bit(J);
                        else      w_ctrl = 16'h0000;
                    end
                    OP_JZ: begin
                        if (i_zf) w_ctrl = ctrl_bit(IO) | ctrl_bit(J);
                        else      w_ctrl = 16'h0000;
                    end
                    OP_OUT:  w_ctrl = ctrl_bit(AO) | ctrl_bit(OI);
                    OP_HLT:  w_ctrl = ctrl_bit(HLT);
                    default: w_ctrl = 16'h0000;
                endcase
            end
            STEP_T3: begin
                case (i_opcode)
                    OP_LDA:         w_ctrl = ctrl_bit(RO) | ctrl_bit(AI);
                    OP_ADD, OP_SUB: w_ctrl = ctrl_bit(RO) | ctrl_bit(BI);
                    OP_STA:         w_ctrl = ctrl_bit(AO) | ctrl_bit(RI);
                    default:        w_ctrl = 16'h0000;
                endcase
            end
            STEP_T4: begin
                case (i_opcode)
                    OP_ADD:  w_ctrl = ctrl_bit(EO) | ctrl_bit(AI) | ctrl_bit(FI);
                    OP_SUB:  w_ctrl = ctrl_bit(EO) | ctrl_bit(AI) | ctrl_bit(SU) | ctrl_bit(FI);
                    default: w_ctrl = 16'h0000;
                endcase
            end
            default: w_ctrl = 16'h0000;
        endcase
    end

    assign o_uop.ctrl = w_ctrl;
    assign o_uop.last = (i_step == last_step(i_opcode));

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: owns the T-state counter, the halt latch and
// reset gating of the control word; decode lives in microcode_rom.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit EARLY_END  = 1'b1,
    parameter int STEP_COUNT = 5
) (
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.slave  bus
);

    localparam logic [2:0] STEP_LAST = 3'(STEP_COUNT - 1);

    uop_t       w_uop;
    logic       w_halt_now;
    logic       w_wrap;
    logic [2:0] w_step_nxt;
    logic [2:0] r_step;
    logic       r_halted;

    microcode_rom u_rom (
        .i_opcode (bus.opcode),
        .i_step   (r_step),
        .i_cf     (bus.cf),
        .i_zf     (bus.zf),
        .o_uop    (w_uop)
    );

    // Next T-state; the counter freezes at T2 once HLT is reached
    always_comb begin
        w_halt_now = (r_step == STEP_T2) && (bus.opcode == OP_HLT);
        w_wrap     = EARLY_END ? w_uop.last : (r_step == STEP_LAST);
        if (r_halted || w_halt_now) begin
            w_step_nxt = r_step;
        end else if (w_wrap) begin
            w_step_nxt = STEP_T0;
        end else begin
            w_step_nxt = r_step + 3'd1;
        end
    end

    // Step counter and halt latch
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_step   <= STEP_T0;
            r_halted <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_halted <= r_halted | w_halt_now;
        end
    end

    // clr must silence the bus immediately, not at the next edge
    always_comb begin
        if (clr) begin
            bus.ctrl = 16'h0000;
        end else if (r_halted) begin
            bus.ctrl = ctrl_bit(HLT);
        end else begin
            bus.ctrl = w_uop.ctrl;
        end
    end

    assign bus.step   = r_step;
    assign bus.halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: expected outputs are queued with each stimulus cycle and
// compared on the falling edge, away from the capturing rising edge.
module tb_control_sequencer;

    typedef struct packed {
        logic        sel;
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        halted;
    } exp_t;

    logic clk;
    logic clr1;
    logic clr0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    control_sequencer_if bus1 ();
    control_sequencer_if bus0 ();

    control_sequencer #(.EARLY_END(1'b1), .STEP_COUNT(5)) dut_early (
        .clk (clk),
        .clr (clr1),
        .bus (bus1.slave)
    );

    control_sequencer #(.EARLY_END(1'b0), .STEP_COUNT(5)) dut_full (
        .clk (clk),
        .clr (clr0),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit sel, input logic [2:0] s,
                              input logic [15:0] c, input logic h);
        exp_t e;
        e.sel = sel; e.step = s; e.ctrl = c; e.halted = h;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        exp_t        e;
        string       t;
        logic [15:0] got_c;
        logic [2:0]  got_s;
        logic        got_h;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.sel) begin
                got_c = bus1.ctrl; got_s = bus1.step; got_h = bus1.halted;
            end else begin
                got_c = bus0.ctrl; got_s = bus0.step; got_h = bus0.halted;
            end
            check_val({t, "_ctrl"}, got_c, e.ctrl);
            check_val({t, "_step"}, {13'd0, got_s}, {13'd0, e.step});
            check_val({t, "_halt"}, {15'd0, got_h}, {15'd0, e.halted});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_out();
        @(posedge clk);
        #1;
    endtask

    task automatic exp1(input string tag, input logic [2:0] s, input logic [15:0] c, input logic h);
        expect_out(tag, 1'b1, s, c, h);
        tick();
    endtask

    task automatic exp0(input string tag, input logic [2:0] s, input logic [15:0] c, input logic h);
        expect_out(tag, 1'b0, s, c, h);
        tick();
    endtask

    task automatic fetch1(input string tag);
        exp1({tag, "_t0"}, 3'd0, 16'h4004, 1'b0);
        exp1({tag, "_t1"}, 3'd1, 16'h1408, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        clr1 = 1'b1;
        clr0 = 1'b1;
        bus1.opcode = 4'b0010; bus1.cf = 1'b0; bus1.zf = 1'b0;
        bus0.opcode = 4'b0101; bus0.cf = 1'b0; bus0.zf = 1'b0;

        repeat (3) exp1("rst", 3'd0, 16'h0000, 1'b0);
        clr1 = 1'b0;

        fetch1("add");
        exp1("add_t2", 3'd2, 16'h4800, 1'b0);
        exp1("add_t3", 3'd3, 16'h1020, 1'b0);
        exp1("add_t4", 3'd4, 16'h0281, 1'b0);

        bus1.opcode = 4'b0011;
        fetch1("sub");
        exp1("sub_t2", 3'd2, 16'h4800, 1'b0);
        exp1("sub_t3", 3'd3, 16'h1020, 1'b0);
        exp1("sub_t4", 3'd4, 16'h02C1, 1'b0);

        bus1.opcode = 4'b0111; bus1.cf = 1'b1;
        fetch1("jc1");
        exp1("jc1_t2", 3'd2, 16'h0802, 1'b0);
        bus1.cf = 1'b0;
        fetch1("jc0");
        exp1("jc0_t2", 3'd2, 16'h0000, 1'b0);

        bus1.opcode = 4'b1000; bus1.zf = 1'b1; bus1.cf = 1'b1;
        fetch1("jz1");
        exp1("jz1_t2", 3'd2, 16'h0802, 1'b0);
        bus1.zf = 1'b0;
        fetch1("jz0");
        exp1("jz0_t2", 3'd2, 16'h0000, 1'b0);

        bus1.opcode = 4'b0001;
        fetch1("lda");
        exp1("lda_t2", 3'd2, 16'h4800, 1'b0);
        exp1("lda_t3", 3'd3, 16'h1200, 1'b0);

        bus1.opcode = 4'b1110;
        fetch1("out");
        exp1("out_t2", 3'd2, 16'h0110, 1'b0);

        bus1.opcode = 4'b1111;
        fetch1("hlt");
        exp1("hlt_t2", 3'd2, 16'h8000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus1.opcode = 4'($urandom_range(0, 15));
            exp1("halt_hold", 3'd2, 16'h8000, 1'b1);
        end
        clr1 = 1'b1;
        exp1("halt_clr", 3'd0, 16'h0000, 1'b0);
        clr1 = 1'b0;
        exp1("restart", 3'd0, 16'h4004, 1'b0);

        clr0 = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            exp0("ldi_t0", 3'd0, 16'h4004, 1'b0);
            exp0("ldi_t1", 3'd1, 16'h1408, 1'b0);
            exp0("ldi_t2", 3'd2, 16'h0A00, 1'b0);
            if (rep == 0) begin
                exp0("ldi_t3", 3'd3, 16'h0000, 1'b0);
                exp0("ldi_t4", 3'd4, 16'h0000, 1'b0);
            end
        end
        #2;
        clr0 = 1'b1;
        #1;
        expect_out("async_clr", 1'b0, 3'd0, 16'h0000, 1'b0);
        compare_out();
        exp0("clr_hold", 3'd0, 16'h0000, 1'b0);
        clr0 = 1'b0;
        exp0("clr_release", 3'd0, 16'h4004, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
